pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL wrapper, in the 60 MHz `clock_out` domain.
- Consumes the PLL `locked` flag and produces staged, synchronous, active-high resets for the LED-matrix design.
- Release order: core logic first, then the display driver, after a fixed delay. Any loss of lock re-asserts both resets at once.
- Also reports a saturating lock-loss count for debug LEDs.

Parameters:
- SYNC_STAGES, 2: flops in the `locked` synchroniser chain; must be >= 2.
- LOCK_STABLE_CYCLES, 1024: cycles the synchronised lock must stay high continuously before `reset_core` releases; must be >= 1.
- DISPLAY_DELAY_CYCLES, 256: cycles from `reset_core` release to `reset_display` release; must be >= 1.
- LOSS_COUNT_WIDTH, 8: width of `loss_count`.

Ports:
- clock  input  1  PLL output clock (60 MHz); the only clock.
- reset  input  1  synchronous active-high reset.
- pll_locked  input  1  PLL lock flag; treated as asynchronous to `clock`.
- reset_core  output  1  active-high reset for core logic.
- reset_display  output  1  active-high reset for the matrix scan/display logic.
- ready  output  1  high only when both resets are released.
- loss_count  output  LOSS_COUNT_WIDTH  number of lock losses after full or partial release; saturating.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; the polarity and synchronicity are fixed. All outputs are registered.
- While `reset` is high, on each edge:
  - the sync chain clears to 0 and the state goes to WAIT_LOCK;
  - the counter clears to 0;
  - `reset_core` = 1, `reset_display` = 1, `ready` = 0, `loss_count` = 0.
- Synchroniser: `pll_locked` passes through SYNC_STAGES flops; `locked_s` is the last stage. Only `locked_s` is used.
- Counter width is $clog2(max(LOCK_STABLE_CYCLES, DISPLAY_DELAY_CYCLES)), minimum 1.
- States:
  - WAIT_LOCK: `locked_s` = 1 -> STABILIZE, count <= 0. Otherwise stay.
  - STABILIZE:
    - `locked_s` = 0 -> WAIT_LOCK, count <= 0; `loss_count` is not incremented.
    - count == LOCK_STABLE_CYCLES-1 -> CORE_RUN, `reset_core` <= 0, count <= 0.
    - otherwise count++.
  - CORE_RUN:
    - `locked_s` = 0 -> lock-loss handling (below).
    - count == DISPLAY_DELAY_CYCLES-1 -> ALL_RUN, `reset_display` <= 0, `ready` <= 1.
    - otherwise count++.
  - ALL_RUN: `locked_s` = 0 -> lock-loss handling; otherwise hold.
- Lock-loss handling (from CORE_RUN or ALL_RUN), all on the same edge:
  - state <= WAIT_LOCK, count <= 0;
  - `reset_core` <= 1, `reset_display` <= 1, `ready` <= 0;
  - `loss_count` increments, saturating at all-ones.
- Latency, counting edges from the first edge that samples `pll_locked` = 1, with lock held high:
  - `reset_core` falls after SYNC_STAGES + LOCK_STABLE_CYCLES + 1 edges;
  - `reset_display` falls and `ready` rises DISPLAY_DELAY_CYCLES edges after that.
- Lock-loss latency: from the first edge sampling `pll_locked` = 0 to both resets high is SYNC_STAGES + 1 edges.
- Boundary rules:
  - `reset` high together with a lock drop: `reset` wins and `loss_count` becomes 0.
  - `reset` mid-sequence: immediate return to the reset values; the sequence restarts from WAIT_LOCK.
  - A glitch shorter than one cycle may be missed by the synchroniser; that is acceptable.
  - `reset_display` is never 0 while `reset_core` is 1.
  - `ready` == !`reset_display` at all times.

Decomposition:
- Shared package/header `led_matrix_pkg`: state encoding localparams ST_WAIT_LOCK = 0, ST_STABILIZE = 1, ST_CORE_RUN = 2, ST_ALL_RUN = 3 (2-bit), plus the default stability and delay constants.
- One sub-module: `bit_synchronizer` (parameter STAGES, synchronous clear). It is reused later for button inputs.

Test Plan (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, DISPLAY_DELAY_CYCLES=4, LOSS_COUNT_WIDTH=2):
- `reset` held 3 cycles, `pll_locked` = 0 -> `reset_core` = `reset_display` = 1, `ready` = 0, `loss_count` = 0, indefinitely.
- Release `reset`, raise `pll_locked` before edge 1 -> `reset_core` falls after edge 11; `reset_display` falls and `ready` rises after edge 15.
- Lock high 5 cycles, low 1 cycle, then high -> no release; the count restarts, `reset_core` falls 11 edges after re-lock; `loss_count` stays 0.
- In ALL_RUN, drop `pll_locked` -> both resets high 3 edges later, `loss_count` = 1; re-lock gives the full 11/15-edge sequence again.
- Four lock losses from ALL_RUN -> `loss_count` reads 1, 2, 3, 3 (saturates).
- In CORE_RUN, assert `reset` on the same edge that `locked_s` falls -> all outputs return to reset values, `loss_count` = 0.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED-matrix design.
// Contents:
//   seq_state_t      - 2-bit encoding of the reset sequencer states
//                      (WAIT_LOCK=0, STABILIZE=1, CORE_RUN=2, ALL_RUN=3)
//   DEFAULT_*        - default synchroniser depth, lock-stability and display delays
//   seq_cnt_width()  - width for a counter that must reach max(a,b)-1, minimum 1
package led_matrix_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_CORE_RUN  = 2'd2,
        ST_ALL_RUN   = 2'd3
    } seq_state_t;

    localparam int DEFAULT_SYNC_STAGES          = 2;
    localparam int DEFAULT_LOCK_STABLE_CYCLES   = 1024;
    localparam int DEFAULT_DISPLAY_DELAY_CYCLES = 256;
    localparam int DEFAULT_LOSS_COUNT_WIDTH     = 8;

    function automatic int seq_cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Ports:
//   i_clock - destination clock
//   i_clear - synchronous active-high clear; empties the chain to 0
//   i_d     - asynchronous input bit
//   o_q     - synchronised bit (last stage of the chain)
// STAGES must be >= 2.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic i_clock,
    input  logic i_clear,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset generator driven by the PLL lock flag.
// Releases the core reset once lock has been stable for LOCK_STABLE_CYCLES,
// then the display reset DISPLAY_DELAY_CYCLES later. Losing lock after the
// core release re-asserts both resets together and bumps a saturating
// loss counter.
// Ports:
//   i_clock         - PLL output clock, the only clock
//   i_reset         - synchronous active-high reset
//   i_pll_locked    - PLL lock flag, asynchronous to i_clock
//   o_reset_core    - active-high reset for core logic
//   o_reset_display - active-high reset for matrix scan/display logic
//   o_ready         - high only when both resets are released
//   o_loss_count    - saturating count of lock losses after (partial) release
module pll_reset_sequencer
    import led_matrix_pkg::*;
#(
    parameter int SYNC_STAGES          = DEFAULT_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES   = DEFAULT_LOCK_STABLE_CYCLES,
    parameter int DISPLAY_DELAY_CYCLES = DEFAULT_DISPLAY_DELAY_CYCLES,
    parameter int LOSS_COUNT_WIDTH     = DEFAULT_LOSS_COUNT_WIDTH
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_pll_locked,
    output logic                        o_reset_core,
    output logic                        o_reset_display,
    output logic                        o_ready,
    output logic [LOSS_COUNT_WIDTH-1:0] o_loss_count
);

    localparam int CW = seq_cnt_width(LOCK_STABLE_CYCLES, DISPLAY_DELAY_CYCLES);
    localparam logic [CW-1:0] STAB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(DISPLAY_DELAY_CYCLES - 1);

    logic w_locked_s;

    seq_state_t                  r_state,         w_state_nxt;
    logic [CW-1:0]               r_count,         w_count_nxt;
    logic                        r_reset_core,    w_reset_core_nxt;
    logic                        r_reset_display, w_reset_display_nxt;
    logic                        r_ready;
    logic [LOSS_COUNT_WIDTH-1:0] r_loss_count,    w_loss_count_nxt;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clock (i_clock),
        .i_clear (i_reset),
        .i_d     (i_pll_locked),
        .o_q     (w_locked_s)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= ST_WAIT_LOCK;
            r_count         <= '0;
            r_reset_core    <= 1'b1;
            r_reset_display <= 1'b1;
            r_ready         <= 1'b0;
            r_loss_count    <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_count         <= w_count_nxt;
            r_reset_core    <= w_reset_core_nxt;
            r_reset_display <= w_reset_display_nxt;
            // ready is registered from the same next-value so it can never
            // disagree with the display reset
            r_ready         <= ~w_reset_display_nxt;
            r_loss_count    <= w_loss_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_count_nxt         = r_count;
        w_reset_core_nxt    = r_reset_core;
        w_reset_display_nxt = r_reset_display;
        w_loss_count_nxt    = r_loss_count;

        case (r_state)
            ST_WAIT_LOCK: begin
                w_reset_core_nxt    = 1'b1;
                w_reset_display_nxt = 1'b1;
                if (w_locked_s) begin
                    w_state_nxt = ST_STABILIZE;
                    w_count_nxt = '0;
                end
            end

            ST_STABILIZE: begin
                // dropping lock before core release is not counted as a loss
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_count_nxt = '0;
                end else if (r_count == STAB_LAST) begin
                    w_state_nxt      = ST_CORE_RUN;
                    w_reset_core_nxt = 1'b0;
                    w_count_nxt      = '0;
                end else begin
                    w_count_nxt = r_count + CW'(1);
                end
            end

            ST_CORE_RUN, ST_ALL_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt         = ST_WAIT_LOCK;
                    w_count_nxt         = '0;
                    w_reset_core_nxt    = 1'b1;
                    w_reset_display_nxt = 1'b1;
                    if (r_loss_count != {LOSS_COUNT_WIDTH{1'b1}}) begin
                        w_loss_count_nxt = r_loss_count + LOSS_COUNT_WIDTH'(1);
                    end
                end else if (r_state == ST_CORE_RUN) begin
                    if (r_count == DELAY_LAST) begin
                        w_state_nxt         = ST_ALL_RUN;
                        w_reset_display_nxt = 1'b0;
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_count_nxt = '0;
            end
        endcase
    end

    assign o_reset_core    = r_reset_core;
    assign o_reset_display = r_reset_display;
    assign o_ready         = r_ready;
    assign o_loss_count    = r_loss_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

    localparam int LW = 2;

    logic          clk;
    logic          rst;
    logic          lock;
    logic          reset_core;
    logic          reset_display;
    logic          ready;
    logic [LW-1:0] loss_count;

    int n_checks = 0;
    int n_pass   = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES          (2),
        .LOCK_STABLE_CYCLES   (8),
        .DISPLAY_DELAY_CYCLES (4),
        .LOSS_COUNT_WIDTH     (LW)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_pll_locked    (lock),
        .o_reset_core    (reset_core),
        .o_reset_display (reset_display),
        .o_ready         (ready),
        .o_loss_count    (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          lock;
        logic          core;
        logic          disp;
        logic          rdy;
        logic [LW-1:0] loss;
        string         tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic l, input logic c,
                                input logic d, input logic y,
                                input logic [LW-1:0] n, input string t);
        vec_t v;
        v.rst = r; v.lock = l; v.core = c; v.disp = d; v.rdy = y; v.loss = n; v.tag = t;
        vecs.push_back(v);
    endfunction

    // Lock held high from the first edge: core released after edge 11,
    // display released / ready after edge 15.
    function automatic void add_lock_seq(input logic [LW-1:0] n, input string t);
        for (int e = 1; e <= 15; e++) begin
            if (e <= 10)      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, n, t);
            else if (e <= 14) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, n, t);
            else              add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, n, t);
        end
    endfunction

    task automatic chk1(input string t, input string f, input logic [LW-1:0] got,
                        input logic [LW-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s %s: got %0d want %0d (t=%0t)", t, f, got, want, $time);
    endtask

    task automatic step(input vec_t v);
        rst  = v.rst;
        lock = v.lock;
        @(posedge clk);
        #1;
        chk1(v.tag, "reset_core",    LW'(reset_core),    LW'(v.core));
        chk1(v.tag, "reset_display", LW'(reset_display), LW'(v.disp));
        chk1(v.tag, "ready",         LW'(ready),         LW'(v.rdy));
        chk1(v.tag, "loss_count",    loss_count,         v.loss);
    endtask

    task automatic step_v(input logic r, input logic l, input logic c, input logic d,
                          input logic y, input logic [LW-1:0] n, input string t);
        vec_t v;
        v.rst = r; v.lock = l; v.core = c; v.disp = d; v.rdy = y; v.loss = n; v.tag = t;
        step(v);
    endtask

    task automatic run_lock(input logic [LW-1:0] n, input string t);
        for (int e = 1; e <= 15; e++) begin
            if (e <= 10)      step_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, n, t);
            else if (e <= 14) step_v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, n, t);
            else              step_v(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, n, t);
        end
    endtask

    // Invariant: ready mirrors !reset_display, display never out of reset
    // while core is in reset. Checked on every falling edge.
    int inv_errs = 0;
    always @(negedge clk) begin
        if (ready !== ~reset_display || (reset_core === 1'b1 && reset_display === 1'b0))
            inv_errs++;
    end

    initial begin
        logic [LW-1:0] prev;
        logic [LW-1:0] exp;
        rst  = 1'b1;
        lock = 1'b0;

        // reset held, lock low
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "reset_hold");
        // first lock-up
        add_lock_seq(2'd0, "first_lock");
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, "all_run_hold");
        // lock loss from ALL_RUN: both resets high 3 edges after the drop
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "loss_lat1");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "loss_lat2");
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, "loss_lat3");
        add_lock_seq(2'd1, "relock");
        // reset mid-run, then a one-cycle lock glitch during stabilisation
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, "mid_reset");
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, "mid_reset");
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, "glitch_pre");
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "glitch_low");
        add_lock_seq(2'd0, "glitch_relock");

        foreach (vecs[i]) step(vecs[i]);

        // saturating loss counter: 1, 2, 3, 3
        step_v(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "sat_reset");
        run_lock(2'd0, "sat_lock0");
        prev = 2'd0;
        for (int k = 0; k < 4; k++) begin
            exp = (k < 3) ? LW'(k + 1) : 2'd3;
            step_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, prev, "sat_drop");
            step_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, prev, "sat_drop");
            step_v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, exp,  "sat_count");
            run_lock(exp, "sat_relock");
            prev = exp;
        end

        // reset coinciding with the lock-loss edge while in CORE_RUN
        step_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, "col_drop");
        step_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, "col_drop");
        step_v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, "col_drop");
        for (int e = 1; e <= 10; e++) step_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, "col_lock");
        step_v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, "col_core_run");
        step_v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, "col_core_run");
        step_v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, "col_core_run");
        step_v(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "col_reset");
        step_v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "col_after");
        run_lock(2'd0, "col_restart");

        chk1("invariants", "violations", LW'(inv_errs > 0 ? 1 : 0), 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
